// File: rtl/prio_enc_pipe_if.sv
// Request/result bundle for prio_enc_pipe.
// The slave side is the encoder. The master side is whoever feeds it and drains its results.
interface prio_enc_pipe_if #(
   parameter int unsigned N = 8
);
   localparam int unsigned W = $clog2(N);

   logic         i_valid;
   logic [N-1:0] i_req;
   logic         i_ready;
   logic         o_valid;
   logic [W-1:0] o_idx;
   logic [N-1:0] o_onehot;
   logic         o_none;
   logic         o_ready;

   modport master (
      output i_valid, i_req, o_ready,
      input  i_ready, o_valid, o_idx, o_onehot, o_none
   );

   modport slave (
      input  i_valid, i_req, o_ready,
      output i_ready, o_valid, o_idx, o_onehot, o_none
   );
endinterface

// File: rtl/prio_enc_pipe.sv
// Single-stage registered priority encoder with valid/ready handshake.
// MODE 0 gives fixed priority, where the highest index wins. MODE 1 gives descending round-robin.
module prio_enc_pipe #(
   parameter int unsigned N    = 8,
   parameter int unsigned MODE = 0
) (
   input logic            clk,
   input logic            rst,
   prio_enc_pipe_if.slave bus
);
   localparam int unsigned W      = $clog2(N);
   localparam logic [W-1:0] PtrTop = W'(N - 1);

   logic         ready;
   logic         in_xfer;
   logic [W-1:0] ptr_q;
   logic [W-1:0] cand;
   logic         found;
   logic [W-1:0] win_idx;
   logic [N-1:0] win_onehot;

   logic         valid_q;
   logic [W-1:0] idx_q;
   logic [N-1:0] onehot_q;
   logic         none_q;

   assign ready   = !rst && (!valid_q || bus.o_ready);
   assign in_xfer = bus.i_valid && ready;

   // Walk downward from the pointer. The wrap goes to N-1 so non-power-of-two N never leaves range.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = ptr_q;
      for (int j = 0; j < N; j++) begin
         if (!found && bus.i_req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
         cand = (cand == '0) ? PtrTop : cand - W'(1);
      end
   end

   assign win_onehot = found ? (N'(1) << win_idx) : '0;

   if (MODE == 1) begin : g_rr
      always_ff @(posedge clk) begin
         if (rst) begin
            ptr_q <= PtrTop;
         end else if (in_xfer && found) begin
            ptr_q <= (win_idx == '0) ? PtrTop : win_idx - W'(1);
         end
      end
   end else begin : g_fixed
      assign ptr_q = PtrTop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         idx_q    <= '0;
         onehot_q <= '0;
         none_q   <= 1'b0;
      end else if (in_xfer) begin
         valid_q  <= 1'b1;
         idx_q    <= win_idx;
         onehot_q <= win_onehot;
         none_q   <= !found;
      end else if (bus.o_ready) begin
         valid_q  <= 1'b0;
      end
   end

   assign bus.i_ready  = ready;
   assign bus.o_valid  = valid_q;
   assign bus.o_idx    = idx_q;
   assign bus.o_onehot = onehot_q;
   assign bus.o_none   = none_q;
endmodule

// File: tb/tb_prio_enc_pipe.sv
// Bench for prio_enc_pipe: a fixed-priority N=8 instance, a round-robin N=8 instance and a round-robin N=5 instance.
// All three share the handshake stimulus and are checked against a per-instance reference model.
module tb_prio_enc_pipe;
   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic       ordy;
   logic [7:0] req;

   always #5 clk = ~clk;

   prio_enc_pipe_if #(.N(8)) bus0 ();
   prio_enc_pipe_if #(.N(8)) bus1 ();
   prio_enc_pipe_if #(.N(5)) bus2 ();

   assign bus0.i_valid = valid;
   assign bus0.i_req   = req;
   assign bus0.o_ready = ordy;
   assign bus1.i_valid = valid;
   assign bus1.i_req   = req;
   assign bus1.o_ready = ordy;
   assign bus2.i_valid = valid;
   assign bus2.i_req   = req[4:0];
   assign bus2.o_ready = ordy;

   prio_enc_pipe #(.N(8), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   prio_enc_pipe #(.N(8), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   prio_enc_pipe #(.N(5), .MODE(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int checks = 0;
   int errors = 0;

   int nn[3] = '{8, 8, 5};
   int md[3] = '{0, 1, 1};

   int m_valid[3], m_idx[3], m_oh[3], m_none[3], m_ptr[3];
   logic [31:0] a_irdy[3], a_valid[3], a_idx[3], a_oh[3], a_none[3];

   typedef struct {
      logic [7:0] req;
      int         idx;
      int         oh;
      int         none;
   } vec_t;
   vec_t tbl[6];

   function automatic int hi_bit(input logic [31:0] v);
      int r = -1;
      for (int b = 0; b < 32; b++) if (v[b]) r = b;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sample();
      a_irdy[0] = 32'(bus0.i_ready);  a_valid[0] = 32'(bus0.o_valid);
      a_idx[0]  = 32'(bus0.o_idx);    a_oh[0]    = 32'(bus0.o_onehot);
      a_none[0] = 32'(bus0.o_none);
      a_irdy[1] = 32'(bus1.i_ready);  a_valid[1] = 32'(bus1.o_valid);
      a_idx[1]  = 32'(bus1.o_idx);    a_oh[1]    = 32'(bus1.o_onehot);
      a_none[1] = 32'(bus1.o_none);
      a_irdy[2] = 32'(bus2.i_ready);  a_valid[2] = 32'(bus2.o_valid);
      a_idx[2]  = 32'(bus2.o_idx);    a_oh[2]    = 32'(bus2.o_onehot);
      a_none[2] = 32'(bus2.o_none);
   endtask

   // One clock: check i_ready before the edge, advance the model, then check the registered outputs after the edge.
   task automatic cycle();
      int nv[3], ni[3], no[3], nz[3], np[3];
      logic [31:0] rq, low;
      int start, w;
      @(negedge clk);
      sample();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("i_ready[%0d]", d), a_irdy[d], (!rst && (m_valid[d] == 0 || ordy)) ? 1 : 0);
         nv[d] = m_valid[d]; ni[d] = m_idx[d]; no[d] = m_oh[d];
         nz[d] = m_none[d];  np[d] = m_ptr[d];
         rq = 32'(req) & ((32'd1 << nn[d]) - 1);
         if (rst) begin
            nv[d] = 0; ni[d] = 0; no[d] = 0; nz[d] = 0; np[d] = nn[d] - 1;
         end else if (valid && (m_valid[d] == 0 || ordy)) begin
            start = (md[d] == 1) ? m_ptr[d] : nn[d] - 1;
            low   = rq & ((32'd2 << start) - 1);
            w     = (low != 0) ? hi_bit(low) : hi_bit(rq);
            nv[d] = 1;
            if (rq == 0) begin
               ni[d] = 0; no[d] = 0; nz[d] = 1;
            end else begin
               ni[d] = w; no[d] = 1 << w; nz[d] = 0;
               if (md[d] == 1) np[d] = (w == 0) ? nn[d] - 1 : w - 1;
            end
         end else if (ordy) begin
            nv[d] = 0;
         end
      end
      @(posedge clk);
      #1;
      sample();
      for (int d = 0; d < 3; d++) begin
         m_valid[d] = nv[d]; m_idx[d] = ni[d]; m_oh[d] = no[d];
         m_none[d]  = nz[d]; m_ptr[d] = np[d];
         chk($sformatf("o_valid[%0d]", d), a_valid[d], m_valid[d]);
         if (m_valid[d] == 1) begin
            chk($sformatf("o_idx[%0d]", d), a_idx[d], m_idx[d]);
            chk($sformatf("o_onehot[%0d]", d), a_oh[d], m_oh[d]);
            chk($sformatf("o_none[%0d]", d), a_none[d], m_none[d]);
         end
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      valid = 1'b0;
      cycle();
      rst   = 1'b0;
   endtask

   int exp1[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
   int exp2[9] = '{4, 3, 2, 1, 0, 4, 3, 2, 1};
   int exp84[4] = '{7, 2, 7, 2};

   initial begin
      rst = 1'b1; valid = 1'b0; ordy = 1'b1; req = '0;
      for (int d = 0; d < 3; d++) begin
         m_valid[d] = 0; m_idx[d] = 0; m_oh[d] = 0; m_none[d] = 0; m_ptr[d] = nn[d] - 1;
      end
      tbl[0] = '{8'h96, 7, 8'h80, 0};
      tbl[1] = '{8'h00, 0, 8'h00, 1};
      tbl[2] = '{8'h01, 0, 8'h01, 0};
      tbl[3] = '{8'h3C, 5, 8'h20, 0};
      tbl[4] = '{8'h7F, 6, 8'h40, 0};
      tbl[5] = '{8'h80, 7, 8'h80, 0};

      cycle();
      cycle();
      chk("rst_valid", a_valid[0], 0);
      chk("rst_idx", a_idx[0], 0);
      chk("rst_onehot", a_oh[0], 0);
      chk("rst_none", a_none[0], 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(bus0.i_ready), 1);

      // Fixed-priority vectors, full throughput.
      valid = 1'b1;
      ordy  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req = tbl[i].req;
         cycle();
         chk($sformatf("tbl%0d_valid", i), a_valid[0], 1);
         chk($sformatf("tbl%0d_idx", i), a_idx[0], tbl[i].idx);
         chk($sformatf("tbl%0d_onehot", i), a_oh[0], tbl[i].oh);
         chk($sformatf("tbl%0d_none", i), a_none[0], tbl[i].none);
      end
      valid = 1'b0;
      cycle();
      chk("drain_valid", a_valid[0], 0);

      // Backpressure: the result holds and input is refused until o_ready rises.
      ordy  = 1'b0;
      valid = 1'b1;
      req   = 8'h05;
      cycle();
      chk("bp_first_idx", a_idx[0], 2);
      req = 8'h40;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_hold_idx", a_idx[0], 2);
         chk("bp_hold_ready", a_irdy[0], 0);
      end
      ordy = 1'b1;
      cycle();
      chk("bp_release_idx", a_idx[0], 6);

      // Round-robin with all requesters active: N=8 sees 8'hFF and N=5 sees 5'h1F.
      do_reset();
      valid = 1'b1;
      ordy  = 1'b1;
      req   = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         cycle();
         chk($sformatf("rr8_ff_%0d", i), a_idx[1], exp1[i]);
         chk($sformatf("rr5_1f_%0d", i), a_idx[2], exp2[i]);
      end

      do_reset();
      valid = 1'b1;
      req   = 8'h84;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("rr8_84_%0d", i), a_idx[1], exp84[i]);
      end

      // A reset pulse discards a stalled result and restores the pointer.
      do_reset();
      valid = 1'b1;
      req   = 8'hFF;
      cycle();
      cycle();
      chk("rr_pre_stall_idx", a_idx[1], 6);
      ordy  = 1'b0;
      valid = 1'b0;
      cycle();
      chk("rr_stall_valid", a_valid[1], 1);
      rst = 1'b1;
      cycle();
      chk("rr_rst_discard", a_valid[1], 0);
      rst   = 1'b0;
      ordy  = 1'b1;
      valid = 1'b1;
      cycle();
      chk("rr_after_rst_idx", a_idx[1], 7);

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 39) == 0);
         valid = ($urandom_range(0, 3) != 0);
         ordy  = ($urandom_range(0, 2) != 0);
         req   = 8'($urandom);
         if ($urandom_range(0, 7) == 0) req = '0;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/prio_enc_pipe.md
PRIO_ENC_PIPE -- requirements
Module: prio_enc_pipe

Interface
REQ-001 Parameter N, default 8, number of request inputs; legal range N >= 2, power of two not required.
REQ-002 Parameter MODE, default 0, arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-003 Localparam W = clog2(N), index width (3 for N=8).
REQ-004 Port clk, input, 1, rising-edge clock for all state.
REQ-005 Port rst, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-006 Port i_valid, input, 1, request vector on i_req is valid this cycle.
REQ-007 Port i_req, input, N, request vector; bit k set = requester k active.
REQ-008 Port i_ready, output, 1, block accepts i_req this cycle.
REQ-009 Port o_valid, output, 1, registered result is valid.
REQ-010 Port o_idx, output, W, binary index of the winning request.
REQ-011 Port o_onehot, output, N, one-hot form of the winner; all-zero when no winner.
REQ-012 Port o_none, output, 1, accepted vector was all-zero.
REQ-013 Port o_ready, input, 1, downstream accepts the result this cycle.

Function
REQ-014 Input transfer occurs when i_valid && i_ready; output transfer occurs when o_valid && o_ready.
REQ-015 i_ready = !rst && (!o_valid || o_ready), combinational; no other input-to-output combinational path.
REQ-016 Latency: result for a transfer on cycle t appears on o_* at cycle t+1 with o_valid=1.
REQ-017 Throughput: one transfer per cycle when o_ready is held high.
REQ-018 While o_valid=1 and o_ready=0, o_idx, o_onehot and o_none hold stable and no new input is accepted.
REQ-019 o_valid clears on an output transfer with no simultaneous input transfer; on a simultaneous input transfer, o_valid stays 1 and new data loads.
REQ-020 MODE=0: highest set index wins (bit N-1 highest priority, bit 0 lowest).
REQ-021 MODE=1: search order starts at pointer ptr (W bits), descending with wrap: ptr, ptr-1, ..., 0, N-1, ..., ptr+1; first set bit wins.
REQ-022 MODE=1: on an input transfer with winner k, ptr <= k-1, or ptr <= N-1 when k=0.
REQ-023 Pointer wrap uses N-1, never 2^W-1, so ptr always stays in 0..N-1 for non-power-of-two N.
REQ-024 All-zero vector accepted: o_none=1, o_idx=0, o_onehot=0; ptr unchanged.
REQ-025 Non-zero vector accepted: o_none=0, o_onehot has exactly the winner bit set, o_idx = winner.
REQ-026 MODE=0 keeps no pointer state; its behaviour equals MODE=1 with ptr fixed at N-1.
REQ-027 i_req is ignored when no input transfer occurs; ptr changes only on input transfers.

Reset
REQ-028 rst high at a rising edge sets o_valid=0, o_idx=0, o_onehot=0, o_none=0, ptr=N-1.
REQ-029 rst has priority over any simultaneous input or output transfer; an in-flight result is discarded, not delivered.
REQ-030 The first cycle after rst deasserts has i_ready=1, and behaviour matches fixed priority until the first grant.

Verification
REQ-031 N=8, MODE=0, o_ready=1, i_req=8'b1001_0110 -> next cycle o_valid=1, o_idx=7, o_onehot=8'h80, o_none=0.
REQ-032 N=8, MODE=0, i_req=8'h00 -> o_valid=1, o_none=1, o_idx=0, o_onehot=8'h00.
REQ-033 Backpressure, o_ready=0: accept 8'h05, then hold 8'h40 on i_req -> o_idx=2 held and i_ready=0; raise o_ready -> next cycle o_idx=6.
REQ-034 N=8, MODE=1, i_req=8'hFF back-to-back for 9 transfers, o_ready=1 -> o_idx sequence 7,6,5,4,3,2,1,0,7.
REQ-035 N=8, MODE=1, i_req=8'b1000_0100 repeated -> o_idx 7,2,7,2; N=5, MODE=1, 5'h1F repeated -> 4,3,2,1,0,4.
REQ-036 MODE=1 after two 8'hFF grants, o_valid=1, o_ready=0: pulse rst one cycle -> o_valid=0 and no result delivered; next 8'hFF -> o_idx=7.
